// File: rtl/golden_nonce_reporter.sv
// golden_nonce_reporter: captures golden nonces from the miner, queues them, and reports them over UART 8N1.
// Define GOLDEN_NONCE_HEX_EN to send 8 lowercase hex digits plus LF per nonce instead of 4 raw bytes.
module golden_nonce_reporter #(
  parameter int CLKS_PER_BIT    = 434,
  parameter int FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     hit,
  input  logic [31:0]              nonce,
  output logic                     tx_out,
  output logic                     busy,
  output logic                     overflow,
  output logic [FIFO_DEPTH_LOG2:0] fifo_level
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
`ifdef GOLDEN_NONCE_HEX_EN
  localparam int MSG_BYTES = 9;
`else
  localparam int MSG_BYTES = 4;
`endif
  localparam logic [CNT_W-1:0]           CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]                 BYTE_LAST = 4'(MSG_BYTES - 1);
  localparam logic [FIFO_DEPTH_LOG2:0]   FULL_CNT  = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                     state;
  logic                       hit_last;
  logic [31:0]                mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
  logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   count;
  logic [31:0]                msg;
  logic [CNT_W-1:0]           clk_cnt;
  logic [2:0]                 bit_idx;
  logic [3:0]                 byte_idx;
  logic [7:0]                 cur_byte;
  logic                       capture;
  logic                       pop;
  logic                       push;

  function automatic logic [7:0] hex_char(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h57 + {4'h0, d});
  endfunction

  // Byte idx of the message built from nonce m.
  function automatic logic [7:0] msg_byte(input logic [31:0] m, input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h0A;
`ifdef GOLDEN_NONCE_HEX_EN
    for (int i = 0; i < 8; i++)
      if (idx == 4'(i)) b = hex_char(m[28-4*i +: 4]);
`else
    for (int i = 0; i < 4; i++)
      if (idx == 4'(i)) b = m[24-8*i +: 8];
`endif
    return b;
  endfunction

  assign capture    = rst_n & hit & ~hit_last;
  assign pop        = rst_n & (state == IDLE) & (count != '0);
  assign push       = capture & ((count != FULL_CNT) | pop);
  assign cur_byte   = msg_byte(msg, byte_idx);
  assign busy       = (count != '0) | (state != IDLE);
  assign fifo_level = count;

  // Capture and FIFO bookkeeping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_last <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      hit_last <= hit;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (capture && !push) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= nonce;
    if (pop)  msg <= mem[rd_ptr];
  end

  // UART transmitter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_out   <= 1'b1;
      clk_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          if (pop) begin
            state    <= START;
            tx_out   <= 1'b0;
            byte_idx <= '0;
            clk_cnt  <= '0;
            bit_idx  <= '0;
          end
        end
        START: begin
          if (clk_cnt == CNT_LAST) begin
            state   <= DATA;
            tx_out  <= cur_byte[0];
            clk_cnt <= '0;
            bit_idx <= '0;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              tx_out  <= 1'b1;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx_out  <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            if (byte_idx == BYTE_LAST) begin
              state  <= IDLE;
              tx_out <= 1'b1;
            end else begin
              byte_idx <= byte_idx + 1'b1;
              state    <= START;
              tx_out   <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_golden_nonce_reporter.sv
// Bench for golden_nonce_reporter: UART decoder plus transaction-level reference model, directed and random stimulus.
module tb_golden_nonce_reporter;
  localparam int CPB   = 4;
  localparam int DL2   = 2;
  localparam int DEPTH = 1 << DL2;
`ifdef GOLDEN_NONCE_HEX_EN
  localparam int MSG_LEN = 9;
`else
  localparam int MSG_LEN = 4;
`endif
  localparam int LEN = MSG_LEN * 10 * CPB;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           hit = 1'b0;
  logic [31:0]    nonce = '0;
  logic           tx_out;
  logic           busy;
  logic           overflow;
  logic [DL2:0]   fifo_level;

  golden_nonce_reporter #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst_n(rst_n), .hit(hit), .nonce(nonce),
    .tx_out(tx_out), .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] msg_byte(input logic [31:0] n, input int i);
`ifdef GOLDEN_NONCE_HEX_EN
    string s;
    s = $sformatf("%08x\n", n);
    return s[i];
`else
    return 8'(n >> (8 * (3 - i)));
`endif
  endfunction

  // Reference model: queue of waiting nonces, time the transmitter becomes free.
  int           cyc = 0;
  logic [31:0]  m_q[$];
  logic [7:0]   exp_q[$];
  bit           m_ovf = 0;
  bit           m_hl = 0;
  int           m_end = 0;
  bit           chk_en = 0;
  int           peak = 0;

  always @(posedge clk) begin
    bit pop_now;
    bit cap_now;
    logic [31:0] n;
    cyc++;
    if (!rst_n) begin
      m_q.delete();
      exp_q.delete();
      m_ovf = 0;
      m_hl  = 0;
      m_end = cyc;
    end else begin
      pop_now = (cyc > m_end) && (m_q.size() != 0);
      cap_now = hit && !m_hl;
      m_hl = hit;
      if (pop_now) begin
        n = m_q.pop_front();
        for (int i = 0; i < MSG_LEN; i++) exp_q.push_back(msg_byte(n, i));
        m_end = cyc + LEN;
      end
      if (cap_now) begin
        if (m_q.size() < DEPTH) m_q.push_back(nonce);
        else m_ovf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("fifo_level", fifo_level, m_q.size());
      check("busy", busy, (m_q.size() != 0) || (cyc < m_end));
      check("overflow", overflow, m_ovf);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
  end

  // UART receiver sampling mid-bit.
  int          dcnt = 0;
  bit          drx = 0;
  logic [7:0]  dbyte = '0;
  logic [7:0]  rxq[$];
  int          start_cnt = 0;
  int          start_cyc = 0;

  always @(negedge clk) begin
    int b;
    if (!rst_n) begin
      drx = 0;
    end else if (!drx) begin
      if (tx_out === 1'b0) begin
        drx = 1;
        dcnt = 0;
        start_cnt++;
        start_cyc = cyc;
      end
    end else begin
      dcnt++;
      if (dcnt % CPB == CPB / 2) begin
        b = dcnt / CPB;
        if (b == 0) begin
          check("start_bit", tx_out, 1'b0);
        end else if (b <= 8) begin
          dbyte[b-1] = tx_out;
        end else begin
          check("stop_bit", tx_out, 1'b1);
          rxq.push_back(dbyte);
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL rx_unexpected: got %0h, expected no byte", dbyte);
          end else begin
            check("rx_byte", dbyte, exp_q.pop_front());
          end
          drx = 0;
        end
      end
    end
  end

  typedef struct {
    logic [31:0] nonce;
    logic [31:0] raw;
    logic [71:0] hex;
  } vec_t;
  vec_t vt[5];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      step();
      n++;
    end
    check({name, "_idle"}, busy, 1'b0);
  endtask

  task automatic pulse(input logic [31:0] v);
    step();
    hit = 1'b1;
    nonce = v;
    step();
    hit = 1'b0;
  endtask

  initial begin
    int n_cap;
    int s0;
    int lows;
    logic [7:0] e;

    vt[0] = '{32'h0E33337A, 32'h0E33337A, {"0e33337a", 8'h0A}};
    vt[1] = '{32'h00000000, 32'h00000000, {"00000000", 8'h0A}};
    vt[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, {"ffffffff", 8'h0A}};
    vt[3] = '{32'hA5C39F10, 32'hA5C39F10, {"a5c39f10", 8'h0A}};
    vt[4] = '{32'h9ABCDEF1, 32'h9ABCDEF1, {"9abcdef1", 8'h0A}};

    // Reset with hit toggling underneath.
    rst_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      hit = (i % 2 == 1) && (i < 8);
      nonce = $urandom;
    end
    check("rst_tx_out", tx_out, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_fifo_level", fifo_level, '0);
    chk_en = 1;
    rst_n = 1'b1;
    repeat (20) step();
    check("no_tx_after_reset", start_cnt, 0);

    // Single captures from the vector table.
    for (int k = 0; k < 5; k++) begin
      rxq.delete();
      s0 = start_cnt;
      step();
      hit = 1'b1;
      nonce = vt[k].nonce;
      n_cap = cyc + 1;
      step();
      hit = 1'b0;
      for (int w = 0; w < 4 && start_cnt == s0; w++) step();
      check("first_start_cycle", start_cyc, n_cap + 1);
      wait_idle(LEN + 20, "single");
      check("busy_drop_cycle", cyc, n_cap + 1 + LEN);
      step();
      check("single_len", rxq.size(), MSG_LEN);
      for (int i = 0; i < MSG_LEN && i < rxq.size(); i++) begin
`ifdef GOLDEN_NONCE_HEX_EN
        e = vt[k].hex[71-8*i -: 8];
`else
        e = vt[k].raw[31-8*i -: 8];
`endif
        check("single_byte", rxq[i], e);
      end
    end

    // Level hit: one capture only.
    rxq.delete();
    step();
    hit = 1'b1;
    nonce = 32'h12345678;
    repeat (100) step();
    hit = 1'b0;
    wait_idle(LEN + 20, "level");
    step();
    check("level_len", rxq.size(), MSG_LEN);
    for (int i = 0; i < MSG_LEN && i < rxq.size(); i++)
      check("level_byte", rxq[i], msg_byte(32'h12345678, i));
    check("level_overflow", overflow, 1'b0);

    // Overflow: six captures two cycles apart.
    rxq.delete();
    peak = 0;
    for (int k = 1; k <= 6; k++) begin
      pulse(32'(k));
      check("ovf_flag", overflow, k == 6);
    end
    wait_idle(6 * (LEN + 1) + 50, "ovf");
    check("ovf_peak", peak, DEPTH);
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_len", rxq.size(), 5 * MSG_LEN);
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < MSG_LEN && (k * MSG_LEN + i) < rxq.size(); i++)
        check("ovf_byte", rxq[k*MSG_LEN+i], msg_byte(32'(k + 1), i));
    step();
    rst_n = 1'b0;
    step();
    check("ovf_cleared", overflow, 1'b0);
    rst_n = 1'b1;
    repeat (3) step();

    // Push and pop on the same edge with the FIFO full.
    rxq.delete();
    n_cap = cyc + 2;
    for (int k = 1; k <= 5; k++) pulse(32'(k * 32'h11));
    check("full_level", fifo_level, DEPTH);
    while (cyc < n_cap + LEN + 1) step();
    hit = 1'b1;
    nonce = 32'h66;
    step();
    hit = 1'b0;
    check("full_pushpop_level", fifo_level, DEPTH);
    check("full_pushpop_ovf", overflow, 1'b0);
    wait_idle(6 * (LEN + 1) + 50, "full");
    check("full_len", rxq.size(), 6 * MSG_LEN);
    for (int k = 0; k < 6; k++)
      for (int i = 0; i < MSG_LEN && (k * MSG_LEN + i) < rxq.size(); i++)
        check("full_byte", rxq[k*MSG_LEN+i], msg_byte(32'((k + 1) * 32'h11), i));

    // Reset during bit 3 of byte 1, with a second nonce queued.
    step();
    hit = 1'b1;
    nonce = 32'hA5A5A5A5;
    n_cap = cyc + 1;
    step();
    hit = 1'b0;
    pulse(32'h5A5A5A5A);
    while (cyc < n_cap + 58) step();
    rst_n = 1'b0;
    step();
    check("midreset_tx", tx_out, 1'b1);
    check("midreset_level", fifo_level, '0);
    rst_n = 1'b1;
    s0 = start_cnt;
    lows = 0;
    repeat (200) begin
      step();
      if (tx_out !== 1'b1) lows++;
    end
    check("midreset_tx_low_cycles", lows, 0);
    check("midreset_starts", start_cnt, s0);

    // Hit held high through reset counts as a new edge on release.
    step();
    hit = 1'b1;
    nonce = 32'hCAFEF00D;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    s0 = start_cnt;
    repeat (5) step();
    check("hit_through_reset", start_cnt, s0 + 1);
    hit = 1'b0;
    wait_idle(LEN + 20, "hitrst");

    // Randomized traffic against the reference model.
    for (int c = 0; c < 3000; c++) begin
      step();
      if ($urandom_range(0, 99) < 10) hit = ~hit;
      nonce = $urandom;
      rst_n = ($urandom_range(0, 999) != 0);
    end
    step();
    hit = 1'b0;
    rst_n = 1'b1;
    wait_idle((DEPTH + 2) * (LEN + 1) + 100, "random");
    repeat (3) step();
    check("random_all_delivered", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/golden_nonce_reporter.md
# golden_nonce_reporter

Downstream consumer of `bitcoin_miner`: watches the miner's `hit`/`nonce` outputs, captures each golden nonce on the rising edge of `hit`, and buffers it in a small FIFO. It then serialises each buffered nonce to the host over a UART 8N1 transmit line. It sits between the miner core and the board's serial pin, so nonces found while a previous report is still in flight are not lost.

## Interface
- `CLKS_PER_BIT`, default 434: clk cycles per UART bit (50 MHz / 115200). Must be ≥ 2.
- `FIFO_DEPTH_LOG2`, default 2: FIFO depth = 2^FIFO_DEPTH_LOG2 nonces (default 4).
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, synchronous, active-low.
- `hit` input 1: miner hit flag; may stay high for many cycles.
- `nonce` input 32: miner nonce; valid in the cycle `hit` is first sampled high.
- `tx_out` output 1: UART TX line, registered, idle high.
- `busy` output 1: high while the FIFO is non-empty or the transmitter is not IDLE.
- `overflow` output 1: sticky; set when a captured nonce is dropped because the FIFO is full.
- `fifo_level` output FIFO_DEPTH_LOG2+1: number of nonces currently stored (excludes the one in flight).

## Operation
- **Edge detect:** `hit_last` is registered and resets to 0. A capture event occurs on a clock edge where `hit`=1 and `hit_last`=0. `nonce` is sampled on that same edge. A `hit` held high produces exactly one capture.
- **FIFO:** circular buffer with a read pointer, a write pointer and a count.
  - Push on a capture event if the FIFO is not full, or if a pop happens on the same edge.
  - Otherwise drop the nonce and set `overflow`=1; it stays set until reset.
  - Pointers wrap modulo depth.
- **Transmitter FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** `tx_out`=1. If `fifo_level`≠0, pop the head into the message shift register, set byte index = 0, and go to START.
  - **START:** `tx_out`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - **DATA:** send 8 bits LSB-first, each for CLKS_PER_BIT cycles, then go to STOP.
  - **STOP:** `tx_out`=1 for CLKS_PER_BIT cycles. Then, if more bytes remain in the message, advance the byte index and go to START (no idle gap); otherwise go to IDLE.
- **Raw message (default):** 4 bytes, `nonce[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`, in that order.
- **Counters:** the bit-period counter and the bit index are sized to their maximum values and reset to 0 on every state transition.

## Timing
- Reset values: `tx_out`=1, `busy`=0, `overflow`=0, `fifo_level`=0, FSM=IDLE, pointers=0, `hit_last`=0.
- **Capture-to-line latency:** if a capture occurs at edge N with the FSM in IDLE and the FIFO empty:
  - push happens at N;
  - pop happens at N+1, and `tx_out` goes low from edge N+1 onward.
- **Frame length:** 10·CLKS_PER_BIT cycles per byte. A raw message takes 40·CLKS_PER_BIT cycles.
- **Between messages:** exactly one IDLE cycle with `tx_out`=1 follows the last stop bit, then the next pop.
- **Simultaneous push and pop:** both succeed, and `fifo_level` is unchanged. This applies even when the FIFO is full.
- **Reset mid-frame:** on the next edge `tx_out`=1 and the FSM is IDLE. The FIFO is flushed, `overflow` clears, and the partial frame is abandoned.
- **`hit` asserted during reset:** it is ignored. `hit_last` is forced to 0 during reset, so a `hit` still high after release counts as a new edge.

## Configuration
- **`GOLDEN_NONCE_HEX_EN` defined:** each message is 9 ASCII bytes: 8 lowercase hex digits, most significant nibble first (`0`–`9` → 0x30–0x39, `a`–`f` → 0x61–0x66), followed by 0x0A. Message length is 90·CLKS_PER_BIT cycles.
- **`GOLDEN_NONCE_HEX_EN` undefined:** each message is the 4 raw bytes described under Operation.
- The FIFO, edge detect and FSM are identical in both modes; only the byte source and the message length differ.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH_LOG2=2.

- **Reset:** hold `rst_n`=0 for 10 cycles → `tx_out`=1, `busy`=0, `overflow`=0, `fifo_level`=0. Toggling `hit` during reset causes no transmission.
- **Raw single capture:** one-cycle `hit` with `nonce`=0x0E33337A, captured at edge N →
  - `tx_out` falls at edge N+1;
  - bench UART decoder receives 0x0E, 0x33, 0x33, 0x7A;
  - `busy` drops 160 cycles after edge N+1.
- **Hex single capture:** same stimulus with `GOLDEN_NONCE_HEX_EN` defined → decoder receives 0x30 0x65 0x33 0x33 0x33 0x33 0x37 0x61 0x0A, spanning 360 cycles.
- **Level hit:** `hit` held high for 100 cycles with `nonce`=0x12345678 → exactly one message, 0x12 0x34 0x56 0x78, and `overflow` stays 0.
- **Overflow:** six 1-cycle `hit` pulses, 2 cycles apart, with nonces 1..6 →
  - nonces 1–5 are reported in order;
  - nonce 6 is dropped;
  - `overflow`=1 from the 6th capture edge until reset;
  - peak `fifo_level`=4.
- **Reset mid-frame:** assert `rst_n`=0 during bit 3 of byte 1, release, then wait 200 cycles → `tx_out`=1 on the edge after reset and stays high, with no further start bits.
